switch_led_bank: RTL

Parametrised bank of N switch-to-LED channels. Each channel synchronises and debounces one raw board switch and drives one LED in one of four modes: follow, toggle-on-press, blink-while-on, or forced off. The block sits directly behind the board switch pins and in front of the LED pins, and is the clocked successor to the direct switch-to-LED wire. It also exports one-cycle press pulses for other logic.

---
 rtl/switch_led_pkg.sv | 15 +
 rtl/switch_debounce.sv | 45 ++++
 rtl/switch_led_bank.sv | 79 +++++++
 3 files changed

// File: rtl/switch_led_pkg.sv
// rtl/switch_led_pkg.sv - shared LED mode encoding and debounce counter sizing
package switch_led_pkg;

    typedef enum logic [1:0] {
        FOLLOW = 2'b00,
        TOGGLE = 2'b01,
        BLINK  = 2'b10,
        OFF    = 2'b11
    } led_mode_t;

    function automatic int debounce_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - one channel: 2-flop synchroniser, debouncer, rise detector
module switch_debounce
    import switch_led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic switch,
    output logic level,
    output logic rise
);

    localparam int CW = debounce_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            count <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= switch;
            sync2 <= sync1;
            rise  <= 1'b0;
            if (sync2 == level) begin
                count <= '0;
            end else if (count == LAST) begin
                // rise is registered alongside level so it marks a 0->1 acceptance
                level <= ~level;
                rise  <= ~level;
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/switch_led_bank.sv
// rtl/switch_led_bank.sv - N debounced switch channels driving LEDs in a global mode
module switch_led_bank
    import switch_led_pkg::*;
#(
    parameter int N                 = 4,
    parameter int DEBOUNCE_CYCLES   = 1000,
    parameter int BLINK_HALF_PERIOD = 25_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] switch,
    input  logic [1:0]   mode,
    output logic [N-1:0] led,
    output logic [N-1:0] press,
    output logic [N-1:0] level
);

    localparam int BW = $clog2(BLINK_HALF_PERIOD + 1);
    localparam logic [BW-1:0] BLAST = BW'(BLINK_HALF_PERIOD - 1);

    logic [N-1:0]  rise;
    logic [N-1:0]  tog;
    logic [N-1:0]  tog_next;
    logic [N-1:0]  led_next;
    logic [BW-1:0] blink_count;
    logic          phase;
    led_mode_t     mode_sel;

    for (genvar i = 0; i < N; i++) begin : g_chan
        switch_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .rst   (rst),
            .switch(switch[i]),
            .level (level[i]),
            .rise  (rise[i])
        );
    end

    // press is rise delayed one cycle, so toggling on rise lines the LED up with press
    assign tog_next = tog ^ rise;
    assign mode_sel = led_mode_t'(mode);

    always_comb begin
        led_next = '0;
        case (mode_sel)
            FOLLOW:  led_next = level;
            TOGGLE:  led_next = tog_next;
            BLINK:   led_next = level & {N{phase}};
            default: led_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_count <= '0;
            phase       <= 1'b0;
        end else if (blink_count == BLAST) begin
            blink_count <= '0;
            phase       <= ~phase;
        end else begin
            blink_count <= blink_count + BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tog   <= '0;
            press <= '0;
            led   <= '0;
        end else begin
            tog   <= tog_next;
            press <= rise;
            led   <= led_next;
        end
    end

endmodule
